// File: rtl/cell_sort_ctrl.sv
// cell_sort_ctrl: frame sequencer for one cell_sort instance, with shadow-bank readout.
// Optional idle-timeout frame close: define CELL_SORT_CTRL_TIMEOUT_EN.
`default_nettype none

module cell_sort_ctrl #(
   parameter int SORTB    = 8,
   parameter int METAB    = 32,
   parameter int DEPTH    = 8,
   parameter int SORT_LAT = 2,
   parameter int TIMEOUT  = 255
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [SORTB-1:0]             s_data_i,
   input  logic [METAB-1:0]             s_meta_i,
   input  logic                         s_valid_i,
   input  logic                         s_last_i,
   output logic                         s_ready_o,
   output logic                         sort_rst_o,
   output logic [SORTB-1:0]             sort_data_o,
   output logic [METAB-1:0]             sort_meta_o,
   output logic                         sort_dav_o,
   input  logic [DEPTH-1:0][SORTB-1:0]  sort_data_i,
   input  logic [DEPTH-1:0][METAB-1:0]  sort_meta_i,
   output logic [SORTB-1:0]             m_data_o,
   output logic [METAB-1:0]             m_meta_o,
   output logic [$clog2(DEPTH)-1:0]     m_rank_o,
   output logic                         m_valid_o,
   output logic                         m_last_o,
   input  logic                         m_ready_i,
   output logic [15:0]                  frame_cnt_o
);

   localparam int RANKB = $clog2(DEPTH);
   localparam int NRESB = $clog2(DEPTH + 1);
   localparam int DLB   = $clog2(SORT_LAT + 2);

   generate
      if (TIMEOUT < 1) begin : g_timeout_chk
         $error("cell_sort_ctrl: TIMEOUT must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      FILL  = 3'd0,
      DRAIN = 3'd1,
      HOLD  = 3'd2,
      SNAP  = 3'd3,
      CLEAR = 3'd4
   } in_state_t;

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_ACTIVE = 1'b1
   } rd_state_t;

   in_state_t          in_state, in_next;
   rd_state_t          rd_state, rd_next;
   logic [15:0]        cnt;
   logic [DLB-1:0]     dcnt;
   logic [NRESB-1:0]   nres;
   logic [RANKB-1:0]   rd_ptr;
   logic [15:0]        frame_cnt;
   logic [SORTB-1:0]   shadow_k [DEPTH];
   logic [METAB-1:0]   shadow_m [DEPTH];

   logic s_hs;
   logic m_hs;
   logic m_final;
   logic bank_free;
   logic drain_done;
   logic timeout;

   assign s_ready_o  = (in_state == FILL);
   assign sort_rst_o = (in_state == CLEAR);
   assign s_hs       = s_valid_i & s_ready_o;
   assign m_valid_o  = (rd_state == RD_ACTIVE);
   assign m_last_o   = m_valid_o && (NRESB'(rd_ptr) == (nres - NRESB'(1)));
   assign m_hs       = m_valid_o & m_ready_i;
   assign m_final    = m_hs & m_last_o;
   // The final readout beat frees the bank in the same cycle it is taken.
   assign bank_free  = (rd_state == RD_IDLE) | m_final;
   assign drain_done = (dcnt == DLB'(SORT_LAT));
   assign m_data_o   = shadow_k[rd_ptr];
   assign m_meta_o   = shadow_m[rd_ptr];
   assign m_rank_o   = rd_ptr;
   assign frame_cnt_o = frame_cnt;

`ifdef CELL_SORT_CTRL_TIMEOUT_EN
   logic [15:0] idle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if ((in_state != FILL) || s_hs) begin
         idle_cnt <= '0;
      end else if ((cnt != 16'd0) && !s_valid_i && (idle_cnt != 16'hFFFF)) begin
         idle_cnt <= idle_cnt + 16'd1;
      end
   end

   // Fires on the TIMEOUT-th consecutive idle cycle of a non-empty frame.
   assign timeout = (in_state == FILL) && (cnt != 16'd0) && !s_valid_i &&
                    (idle_cnt == 16'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_state <= CLEAR;
         rd_state <= RD_IDLE;
      end else begin
         in_state <= in_next;
         rd_state <= rd_next;
      end
   end

   always_comb begin
      in_next = in_state;
      case (in_state)
         FILL:    if ((s_hs && s_last_i) || timeout) in_next = DRAIN;
         DRAIN:   if (drain_done) in_next = bank_free ? SNAP : HOLD;
         HOLD:    if (bank_free) in_next = SNAP;
         SNAP:    in_next = CLEAR;
         CLEAR:   in_next = FILL;
         default: in_next = CLEAR;
      endcase
   end

   always_comb begin
      rd_next = rd_state;
      if (in_state == SNAP) begin
         rd_next = RD_ACTIVE;
      end else if (m_final) begin
         rd_next = RD_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sort_dav_o  <= 1'b0;
         sort_data_o <= '0;
         sort_meta_o <= '0;
      end else begin
         sort_dav_o <= s_hs;
         if (s_hs) begin
            sort_data_o <= s_data_i;
            sort_meta_o <= s_meta_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         dcnt <= '0;
      end else begin
         if (in_state == SNAP) begin
            cnt <= '0;
         end else if (s_hs && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
         end
         if (in_state != DRAIN) begin
            dcnt <= '0;
         end else if (!drain_done) begin
            dcnt <= dcnt + DLB'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nres      <= '0;
         frame_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            shadow_k[i] <= '0;
            shadow_m[i] <= '0;
         end
      end else if (in_state == SNAP) begin
         nres      <= (cnt >= 16'(DEPTH)) ? NRESB'(DEPTH) : cnt[NRESB-1:0];
         frame_cnt <= frame_cnt + 16'd1;
         for (int i = 0; i < DEPTH; i++) begin
            shadow_k[i] <= sort_data_i[i];
            shadow_m[i] <= sort_meta_i[i];
         end
      end
   end

   // A snapshot restarts readout at rank 0 even if it lands on a final beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
      end else if (in_state == SNAP) begin
         rd_ptr <= '0;
      end else if (m_hs) begin
         rd_ptr <= m_last_o ? '0 : rd_ptr + RANKB'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cell_sort_ctrl.sv
// tb_cell_sort_ctrl: scoreboard bench for cell_sort_ctrl with a behavioural sorter model.
`default_nettype none

module tb_cell_sort_ctrl;

   localparam int SORTB    = 8;
   localparam int METAB    = 32;
   localparam int DEPTH    = 8;
   localparam int SORT_LAT = 2;
   localparam int RANKB    = 3;
`ifdef CELL_SORT_CTRL_TIMEOUT_EN
   localparam int TIMEOUT  = 10;
`else
   localparam int TIMEOUT  = 255;
`endif

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic [SORTB-1:0]            s_data = '0;
   logic [METAB-1:0]            s_meta = '0;
   logic                        s_valid = 1'b0;
   logic                        s_last = 1'b0;
   logic                        s_ready;
   logic                        sort_rst;
   logic [SORTB-1:0]            sort_data;
   logic [METAB-1:0]            sort_meta;
   logic                        sort_dav;
   logic [DEPTH-1:0][SORTB-1:0] sort_data_i;
   logic [DEPTH-1:0][METAB-1:0] sort_meta_i;
   logic [SORTB-1:0]            m_data;
   logic [METAB-1:0]            m_meta;
   logic [RANKB-1:0]            m_rank;
   logic                        m_valid;
   logic                        m_last;
   logic                        m_ready = 1'b0;
   logic [15:0]                 frame_cnt;

   cell_sort_ctrl #(
      .SORTB(SORTB), .METAB(METAB), .DEPTH(DEPTH), .SORT_LAT(SORT_LAT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data_i(s_data), .s_meta_i(s_meta), .s_valid_i(s_valid), .s_last_i(s_last),
      .s_ready_o(s_ready),
      .sort_rst_o(sort_rst), .sort_data_o(sort_data), .sort_meta_o(sort_meta),
      .sort_dav_o(sort_dav), .sort_data_i(sort_data_i), .sort_meta_i(sort_meta_i),
      .m_data_o(m_data), .m_meta_o(m_meta), .m_rank_o(m_rank), .m_valid_o(m_valid),
      .m_last_o(m_last), .m_ready_i(m_ready), .frame_cnt_o(frame_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural sorter: descending keys, ties keep arrival order, SORT_LAT to settle.
   logic [DEPTH-1:0][SORTB-1:0] core_k = '0;
   logic [DEPTH-1:0][METAB-1:0] core_m = '0;
   logic [DEPTH-1:0][SORTB-1:0] dly_k = '0;
   logic [DEPTH-1:0][METAB-1:0] dly_m = '0;
   int                          core_n = 0;

   assign sort_data_i = dly_k;
   assign sort_meta_i = dly_m;

   always @(posedge clk) begin : sorter
      int pos;
      dly_k <= sort_rst ? '0 : core_k;
      dly_m <= sort_rst ? '0 : core_m;
      if (sort_rst) begin
         core_k <= '0;
         core_m <= '0;
         core_n <= 0;
      end else if (sort_dav) begin
         pos = core_n;
         for (int i = DEPTH - 1; i >= 0; i--)
            if (i < core_n && sort_data > core_k[i]) pos = i;
         for (int i = 0; i < DEPTH; i++) begin
            if (i == pos) begin
               core_k[i] <= sort_data;
               core_m[i] <= sort_meta;
            end else if (i > pos) begin
               core_k[i] <= core_k[i-1];
               core_m[i] <= core_m[i-1];
            end
         end
         if (core_n < DEPTH) core_n <= core_n + 1;
      end
   end

   typedef struct packed {
      logic [SORTB-1:0] k;
      logic [METAB-1:0] m;
      logic [RANKB-1:0] rank;
      logic             last;
   } exp_t;

   exp_t             exp_q [$];
   logic [SORTB-1:0] fk [$];
   logic [METAB-1:0] fm [$];
   int               n_tests = 0;
   int               n_fail = 0;
   int               rx_cnt = 0;
   int               meta_seq = 0;
   int               rdy_mode = 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Independent reference: repeated selection of the largest unused key, earliest first.
   task automatic push_expected();
      logic used [0:63];
      int   n, nr, best;
      n  = fk.size();
      nr = (n < DEPTH) ? n : DEPTH;
      for (int i = 0; i < 64; i++) used[i] = 1'b0;
      for (int r = 0; r < nr; r++) begin
         best = -1;
         for (int i = 0; i < n; i++)
            if (!used[i] && (best < 0 || fk[i] > fk[best])) best = i;
         used[best] = 1'b1;
         exp_q.push_back('{k: fk[best], m: fm[best], rank: RANKB'(r), last: (r == nr - 1)});
      end
      fk.delete();
      fm.delete();
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send(input logic [SORTB-1:0] key, input logic last);
      int n = 0;
      s_valid = 1'b1;
      s_data  = key;
      s_meta  = {8'hA5, 8'(meta_seq >> 16), 16'(meta_seq)};
      s_last  = last;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) check("s_ready_timeout", 0, 1);
      fk.push_back(key);
      fm.push_back(s_meta);
      meta_seq++;
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   always @(negedge clk) begin
      m_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : rdy_mode[0];
   end

   logic             stall_prev = 1'b0;
   logic [SORTB-1:0] prev_k;
   logic [RANKB-1:0] prev_r;

   always @(negedge clk) begin : monitor
      exp_t e;
      #2;
      if (rst_n && m_valid) begin
         if (stall_prev) begin
            check("hold_key", m_data, prev_k);
            check("hold_rank", m_rank, prev_r);
         end
         if (m_ready) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("key", m_data, e.k);
               check("meta", m_meta, e.m);
               check("rank", m_rank, e.rank);
               check("last", m_last, e.last);
            end
         end
         stall_prev = !m_ready;
         prev_k     = m_data;
         prev_r     = m_rank;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin : main
      int   n, rx0;
      logic [15:0] fc0;

      // Reset and release
      repeat (3) @(negedge clk);
      check("rst_sort_rst", sort_rst, 1);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_dav", sort_dav, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      rst_n = 1'b1;
      #1;
      check("clear_after_release", sort_rst, 1);
      @(negedge clk);
      check("clear_one_cycle", sort_rst, 0);
      check("fill_ready", s_ready, 1);
      check("idle_m_valid", m_valid, 0);

      // Small frame
      rdy_mode = 1;
      send(8'd5, 1'b0);
      send(8'd9, 1'b0);
      send(8'd2, 1'b1);
      push_expected();
      wait_drain(100);
      check("frame_cnt_1", frame_cnt, 1);

      // Oversized frame with random backpressure, then a 1-entry frame
      rdy_mode = 2;
      for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), (i == 19));
      push_expected();
      send(8'd1, 1'b1);
      push_expected();
      wait_drain(400);
      check("frame_cnt_3", frame_cnt, 3);

      // Back-to-back frames with readout stalled: second frame must HOLD
      rdy_mode = 0;
      fc0 = frame_cnt;
      rx0 = rx_cnt;
      for (int i = 0; i < 4; i++) send(8'(10 * i + 3), (i == 3));
      push_expected();
      for (int i = 0; i < 3; i++) send(8'(200 - i), (i == 2));
      push_expected();
      repeat (15) @(negedge clk);
      check("hold_s_ready", s_ready, 0);
      check("hold_frame_cnt", frame_cnt, 16'(fc0 + 1));
      check("hold_no_rx", rx_cnt - rx0, 0);
      rdy_mode = 1;
      wait_drain(200);
      check("b2b_frame_cnt", frame_cnt, 16'(fc0 + 2));
      check("b2b_rx", rx_cnt - rx0, 7);
      check("b2b_ready", s_ready, 1);

      // Reset during readout at rank 3
      for (int i = 0; i < 6; i++) send(8'(40 + 7 * i), (i == 5));
      push_expected();
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         #3;
         if (m_valid && m_rank == 3'd3) break;
         n++;
      end
      check("reach_rank3", m_rank, 3);
      rst_n = 1'b0;
      #1;
      check("async_m_valid", m_valid, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rx0 = rx_cnt;
      repeat (30) @(negedge clk);
      check("no_stale_rx", rx_cnt - rx0, 0);
      check("reset_frame_cnt", frame_cnt, 0);
      send(8'd7, 1'b0);
      send(8'd3, 1'b1);
      push_expected();
      wait_drain(100);
      check("post_reset_rx", rx_cnt - rx0, 2);

      // Frame without last: closes only on idle timeout when enabled
      fc0 = frame_cnt;
      rx0 = rx_cnt;
      for (int i = 0; i < 4; i++) send(8'(90 - 11 * i), 1'b0);
`ifdef CELL_SORT_CTRL_TIMEOUT_EN
      push_expected();
      wait_drain(100);
      check("timeout_frame_cnt", frame_cnt, 16'(fc0 + 1));
      check("timeout_rx", rx_cnt - rx0, 4);
`else
      repeat (40) @(negedge clk);
      check("no_timeout_rx", rx_cnt - rx0, 0);
      check("no_timeout_frame_cnt", frame_cnt, fc0);
      check("no_timeout_ready", s_ready, 1);
      send(8'd50, 1'b1);
      push_expected();
      wait_drain(100);
      check("closed_rx", rx_cnt - rx0, 5);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
